carry_look_ahead_adder: RTL and testbench

- Parameterised-width binary adder with carry-in and carry-out.
- Carries are computed by two-level carry look-ahead logic rather than a ripple chain.
- A combinational result is available in the same cycle. A registered copy of the result, with asynchronous reset, is provided for pipelined datapaths.
- Block-level propagate/generate outputs allow wider adders to cascade multiple instances.

---
 rtl/carry_look_ahead_adder.sv | 113 +++++++++++
 tb/tb_carry_look_ahead_adder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/carry_look_ahead_adder.sv
// Two-level carry look-ahead adder: 4-bit look-ahead groups feed a second-level
// look-ahead unit, with an asynchronously reset output register for pipelining.
module carry_look_ahead_adder #(
    parameter int CLA_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [CLA_WIDTH-1:0] a_i,
    input  logic [CLA_WIDTH-1:0] b_i,
    input  logic                 carry_i,
    output logic [CLA_WIDTH-1:0] sum_o,
    output logic                 carry_o,
    output logic                 group_p_o,
    output logic                 group_g_o,
    output logic [CLA_WIDTH-1:0] sum_q_o,
    output logic                 carry_q_o
);

    localparam int GROUP_W     = 4;
    localparam int GROUP_COUNT = (CLA_WIDTH + GROUP_W - 1) / GROUP_W;

    // Flattened sum-of-products carry out of position 'top':
    // g[top] | p[top]g[top-1] | ... | p[top..0]cin. Every term is a single AND,
    // so the result is two gate levels deep with no ripple between positions.
    function automatic logic look_ahead(
        input logic [15:0] gen,
        input logic [15:0] prop,
        input logic        cin,
        input int          top
    );
        logic carry;
        logic term;
        carry = cin;
        for (int n = 0; n < 16; n++) begin
            if (n <= top) begin
                carry = carry & prop[n];
            end
        end
        for (int m = 0; m < 16; m++) begin
            if (m <= top) begin
                term = gen[m];
                for (int n = 0; n < 16; n++) begin
                    if (n > m && n <= top) begin
                        term = term & prop[n];
                    end
                end
                carry = carry | term;
            end
        end
        return carry;
    endfunction

    logic [CLA_WIDTH-1:0]   p;
    logic [CLA_WIDTH-1:0]   g;
    logic [CLA_WIDTH-1:0]   c;
    logic [GROUP_COUNT:0]   group_c;
    logic [GROUP_COUNT-1:0] group_p;
    logic [GROUP_COUNT-1:0] group_g;
    logic [15:0]            group_p_ext;
    logic [15:0]            group_g_ext;

    assign p           = a_i ^ b_i;
    assign g           = a_i & b_i;
    assign group_c[0]  = carry_i;
    assign group_p_ext = 16'(group_p);
    assign group_g_ext = 16'(group_g);

    genvar gi;
    generate
        // Level 1: each group forms its internal carries from its own carry-in,
        // plus the group propagate/generate pair handed to level 2.
        for (gi = 0; gi < GROUP_COUNT; gi++) begin : g_group
            localparam int LO = gi * GROUP_W;
            localparam int HI = (LO + GROUP_W > CLA_WIDTH) ? CLA_WIDTH - 1 : LO + GROUP_W - 1;
            localparam int GW = HI - LO + 1;

            logic [15:0] gen;
            logic [15:0] prop;

            assign gen   = 16'(g[HI:LO]);
            assign prop  = 16'(p[HI:LO]);
            assign c[LO] = group_c[gi];

            for (genvar bi = 1; bi < GW; bi++) begin : g_bit
                assign c[LO+bi] = look_ahead(gen, prop, group_c[gi], bi - 1);
            end

            assign group_p[gi] = &prop[GW-1:0];
            assign group_g[gi] = look_ahead(gen, prop, 1'b0, GW - 1);
        end

        // Level 2: every group carry-in straight from carry_i and group P/G.
        for (gi = 0; gi < GROUP_COUNT; gi++) begin : g_level2
            assign group_c[gi+1] = look_ahead(group_g_ext, group_p_ext, carry_i, gi);
        end
    endgenerate

    assign sum_o     = p ^ c;
    assign carry_o   = group_c[GROUP_COUNT];
    assign group_p_o = &group_p;
    assign group_g_o = look_ahead(group_g_ext, group_p_ext, 1'b0, GROUP_COUNT - 1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q_o   <= '0;
            carry_q_o <= 1'b0;
        end else begin
            sum_q_o   <= sum_o;
            carry_q_o <= carry_o;
        end
    end

endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// Scoreboard bench for carry_look_ahead_adder at widths 8, 5 and 4: stimulus pushes
// expected results, a monitor pops and checks them one cycle later.
module tb_carry_look_ahead_adder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       carry;
        logic       gp;
        logic       gg;
        bit         fatal;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [7:0] a8 = '0, b8 = '0, sum8, sq8;
    logic [4:0] a5 = '0, b5 = '0, sum5, sq5;
    logic [3:0] a4 = '0, b4 = '0, sum4, sq4;
    logic cin8 = 1'b0, c8, gp8, gg8, cq8;
    logic cin5 = 1'b0, c5, gp5, gg5, cq5;
    logic cin4 = 1'b0, c4, gp4, gg4, cq4;

    exp_t q8[$];
    exp_t q5[$];
    exp_t q4[$];

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    carry_look_ahead_adder #(.CLA_WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .a_i(a8), .b_i(b8), .carry_i(cin8),
        .sum_o(sum8), .carry_o(c8), .group_p_o(gp8), .group_g_o(gg8),
        .sum_q_o(sq8), .carry_q_o(cq8)
    );
    carry_look_ahead_adder #(.CLA_WIDTH(5)) dut5 (
        .clk_i(clk), .rst_i(rst), .a_i(a5), .b_i(b5), .carry_i(cin5),
        .sum_o(sum5), .carry_o(c5), .group_p_o(gp5), .group_g_o(gg5),
        .sum_q_o(sq5), .carry_q_o(cq5)
    );
    carry_look_ahead_adder #(.CLA_WIDTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .a_i(a4), .b_i(b4), .carry_i(cin4),
        .sum_o(sum4), .carry_o(c4), .group_p_o(gp4), .group_g_o(gg4),
        .sum_q_o(sq4), .carry_q_o(cq4)
    );

    task automatic cmp(input string ctx, input string name, input logic [7:0] act,
                       input logic [7:0] exp, input bit fatal);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%s] got=%h want=%h", name, ctx, act, exp);
            if (fatal) begin
                $display("test done: total=%0d bad=%0d", total, bad);
                $fatal(1, "stopping on first random-vector error");
            end
        end
    endtask

    task automatic check_entry(input string tag, input exp_t e, input logic [7:0] s,
                               input logic c, input logic gp, input logic gg,
                               input logic [7:0] sq, input logic cq);
        string ctx;
        ctx = $sformatf("%s a=%h b=%h cin=%b", tag, e.a, e.b, e.cin);
        cmp(ctx, "sum", s, e.sum, e.fatal);
        cmp(ctx, "carry", 8'(c), 8'(e.carry), e.fatal);
        cmp(ctx, "group_p", 8'(gp), 8'(e.gp), e.fatal);
        cmp(ctx, "group_g", 8'(gg), 8'(e.gg), e.fatal);
        cmp(ctx, "identity", 8'(c), 8'(gg | (gp & e.cin)), e.fatal);
        cmp(ctx, "sum_q", sq, e.sum, e.fatal);
        cmp(ctx, "carry_q", 8'(cq), 8'(e.carry), e.fatal);
    endtask

    // Monitor: inputs change at negedge+1, so 1 ns after the next rising edge both
    // the registered copy and the settled combinational outputs reflect that entry.
    always @(posedge clk) begin
        #1;
        if (q8.size() > 0) check_entry("w8", q8.pop_front(), sum8, c8, gp8, gg8, sq8, cq8);
        if (q5.size() > 0) check_entry("w5", q5.pop_front(), 8'(sum5), c5, gp5, gg5, 8'(sq5), cq5);
        if (q4.size() > 0) check_entry("w4", q4.pop_front(), 8'(sum4), c4, gp4, gg4, 8'(sq4), cq4);
    end

    task automatic drive(input int w, input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] es, input logic ec, input logic egp, input logic egg,
                         input bit fatal);
        exp_t e;
        @(negedge clk);
        #1;
        e.a = a; e.b = b; e.cin = cin; e.sum = es; e.carry = ec;
        e.gp = egp; e.gg = egg; e.fatal = fatal;
        case (w)
            8: begin a8 = a; b8 = b; cin8 = cin; q8.push_back(e); end
            5: begin a5 = a[4:0]; b5 = b[4:0]; cin5 = cin; q5.push_back(e); end
            default: begin a4 = a[3:0]; b4 = b[3:0]; cin4 = cin; q4.push_back(e); end
        endcase
        $display("drive w=%0d a=%h b=%h cin=%b expect sum=%h carry=%b", w, a, b, cin, es, ec);
    endtask

    task automatic drive_model(input int w, input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input bit fatal);
        int mask, am, bm, full;
        mask = (1 << w) - 1;
        am   = int'(a) & mask;
        bm   = int'(b) & mask;
        full = am + bm + int'(cin);
        drive(w, 8'(am), 8'(bm), cin, 8'(full & mask), 1'((full >> w) & 1),
              ((am ^ bm) == mask), 1'(((am + bm) >> w) & 1), fatal);
    endtask

    initial begin
        #5;
        cmp("reset", "sum_q w8", sq8, 8'h00, 1'b0);
        cmp("reset", "carry_q w8", 8'(cq8), 8'h00, 1'b0);
        cmp("reset", "sum_q w5", 8'(sq5), 8'h00, 1'b0);
        cmp("reset", "sum_q w4", 8'(sq4), 8'h00, 1'b0);
        @(negedge clk);
        #1 rst = 1'b0;

        // Directed vectors, hand-computed: w, a, b, cin, sum, carry, gp, gg
        drive(8, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(8, 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(8, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(8, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(8, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(5, 8'h1F, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(5, 8'h1F, 8'h1F, 1'b1, 8'h1F, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(5, 8'h10, 8'h0F, 1'b0, 8'h1F, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(8, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);

        // Register path and asynchronous reset; previous edge captured 0xFF.
        @(negedge clk);
        #1;
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        #2;
        cmp("reg", "sum_q holds old", sq8, 8'hFF, 1'b0);
        cmp("reg", "sum comb 0x46", sum8, 8'h46, 1'b0);
        @(posedge clk);
        #1;
        cmp("reg", "sum_q after edge", sq8, 8'h46, 1'b0);
        cmp("reg", "carry_q after edge", 8'(cq8), 8'h00, 1'b0);
        #4 rst = 1'b1;
        #1;
        cmp("reg", "sum_q async reset", sq8, 8'h00, 1'b0);
        cmp("reg", "carry_q async reset", 8'(cq8), 8'h00, 1'b0);
        cmp("reg", "sum comb during reset", sum8, 8'h46, 1'b0);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        cmp("reg", "sum_q no edge yet", sq8, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        cmp("reg", "sum_q reload", sq8, 8'h46, 1'b0);
        $display("register path sequence done");

        for (int i = 0; i < 50; i++)
            drive_model(8, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                        1'($urandom_range(0, 1)), 1'b1);
        for (int i = 0; i < 50; i++)
            drive_model(5, 8'($urandom_range(0, 31)), 8'($urandom_range(0, 31)),
                        1'($urandom_range(0, 1)), 1'b1);
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int ci = 0; ci < 2; ci++)
                    drive_model(4, 8'(a), 8'(b), 1'(ci), 1'b0);

        repeat (3) @(posedge clk);
        #3;
        cmp("drain", "q8 empty", 8'(q8.size()), 8'h00, 1'b0);
        cmp("drain", "q5 empty", 8'(q5.size()), 8'h00, 1'b0);
        cmp("drain", "q4 empty", 8'(q4.size()), 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
